spi_byte_master: RTL

SPI mode-0 initiator that shifts bytes out on MOSI and captures MISO, MSB first, with every SPI signal generated from the FPGA system clock. It is the controller-side counterpart of the FPGA's SPI peripheral block. It is used to drive external SPI devices and as a loopback stimulus source for the peripheral block on the board. A one-byte holding register lets the user queue the next byte during a transfer, so multi-byte frames run back to back with CS held low.

---
 rtl/spi_byte_master_if.sv | 24 ++
 rtl/spi_byte_master.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master_if.sv
// Byte-offer handshake, receive strobe and SPI pins of spi_byte_master.
// The master modport is the design side; the slave modport is the user/board side.
interface spi_byte_master_if;
  logic       txReady;
  logic [7:0] tx;
  logic       oTxFull;
  logic       oBusy;
  logic       oRxReady;
  logic [7:0] oRx;
  logic       oSPIClk;
  logic       oSPIMOSI;
  logic       iSPIMISO;
  logic       oSPICS;

  modport master (
    input  txReady, tx, iSPIMISO,
    output oTxFull, oBusy, oRxReady, oRx, oSPIClk, oSPIMOSI, oSPICS
  );

  modport slave (
    output txReady, tx, iSPIMISO,
    input  oTxFull, oBusy, oRxReady, oRx, oSPIClk, oSPIMOSI, oSPICS
  );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte initiator, MSB first. A one-byte holding register lets the
// next byte queue up so multi-byte frames run back to back under one CS.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_IDLE = 2
) (
  input  logic                  sysclk,
  input  logic                  reset,
  spi_byte_master_if.master     bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_END   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_q, rx_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_q, cs_d;
  logic       busy_q, busy_d;

  logic accept, run, tick, load;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    hold_d    = hold_q;
    full_d    = full_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    rx_rdy_d  = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    load      = 1'b0;

    accept = bus.txReady && !full_q;
    run    = (state_q != ST_IDLE);
    tick   = run && (cnt_q == 8'(CLK_DIV - 1));
    cnt_d  = (!run || tick) ? 8'd0 : cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (full_q) begin
          load      = 1'b1;
          tx_sh_d   = hold_q;
          mosi_d    = hold_q[7];
          cs_d      = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], bus.iSPIMISO};
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], bus.iSPIMISO};
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_d     = rx_sh_q;
              rx_rdy_d = 1'b1;
              // A queued byte continues the frame with no CS gap; MOSI holds otherwise.
              if (full_q) begin
                load    = 1'b1;
                tx_sh_d = hold_q;
                mosi_d  = hold_q[7];
              end else begin
                state_d = ST_END;
              end
            end else begin
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
          end
        end
      end
      ST_END: begin
        if (tick) begin
          cs_d      = 1'b1;
          gap_cnt_d = 4'd0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_cnt_q == 4'(CS_IDLE - 1)) begin
            state_d = ST_IDLE;
            if (!full_q) busy_d = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new offer wins over a same-edge load, keeping the register full.
    if (accept) begin
      hold_d = bus.tx;
      full_d = 1'b1;
      busy_d = 1'b1;
    end else if (load) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      hold_q    <= 8'd0;
      full_q    <= 1'b0;
      tx_sh_q   <= 8'd0;
      rx_sh_q   <= 8'd0;
      rx_q      <= 8'd0;
      rx_rdy_q  <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      rx_rdy_q  <= rx_rdy_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.oTxFull  = full_q;
  assign bus.oBusy    = busy_q;
  assign bus.oRxReady = rx_rdy_q;
  assign bus.oRx      = rx_q;
  assign bus.oSPIClk  = sclk_q;
  assign bus.oSPIMOSI = mosi_q;
  assign bus.oSPICS   = cs_q;

endmodule
